spi_device: RTL and testbench
=============================

Name: spi_device

Overview:
- SPI bus front end that sits directly upstream of the flash-emulation command engine.
- Oversamples the target's SCLK, /CS and MOSI in the system clock domain and delivers per-bit and per-byte receive strobes, with a first-byte command marker.
- Shifts engine-supplied bytes out on MISO, MSB first, in SPI mode 0.
- Drives MISO only when the engine requests output enable and /CS is asserted.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK, /CS and MOSI before edge detection (2 or 3).
- IDLE_TX, 8'hFF, byte shifted out when no tx byte has been supplied for the current byte slot.

Ports:
- clk  in  1  system clock; must be at least 4x SCLK.
- reset  in  1  asynchronous, active-low reset.
- spi_clk_pin  in  1  raw SCLK from the bus.
- spi_cs_pin  in  1  raw /CS from the bus, active-low.
- spi_mosi_pin  in  1  raw MOSI.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  tristate enable for the MISO pad.
- spi_output_enable  in  1  engine request to drive MISO.
- spi_cs  out  1  synchronized /CS, high = idle.
- spi_rx_data  out  8  receive shift register; newest bit in the LSB.
- spi_rx_bit  out  3  index of the bit just received, 0..7.
- spi_rx_bit_strobe  out  1  1-clk pulse per received bit.
- spi_rx_strobe  out  1  1-clk pulse when 8 bits are complete.
- spi_rx_cmd  out  1  1-clk pulse coincident with spi_rx_strobe for the first byte after /CS falls.
- spi_tx_data  in  8  next byte to send.
- spi_tx_strobe  in  1  1-clk load pulse for spi_tx_data.
- tx_late  out  1  sticky; a load missed its byte slot.
- tx_underrun  out  1  sticky; IDLE_TX was sent.

Behaviour:
- Reset values (while reset low, applied asynchronously):
  - spi_miso=1, spi_miso_oe=0, spi_cs=1.
  - spi_rx_data=0, spi_rx_bit=0, all strobes 0.
  - tx_late=0, tx_underrun=0.
  - Synchronizers are preset to SCLK=0 and /CS=1.
- Edge detection: a rising or falling SCLK edge is recognized when the last two synchronized samples differ. Event latency from the pin is SYNC_STAGES+1 clk.
- /CS high (synchronized):
  - Bit counter cleared; spi_rx_data held.
  - first_byte flag set; pending tx slot cleared; spi_miso_oe=0.
  - SCLK edges ignored.
  - Sticky flags are not cleared; only reset clears them.
- Receive, on each SCLK rising edge with /CS low:
  - spi_rx_data <= {spi_rx_data[6:0], mosi}.
  - spi_rx_bit <= bit counter; spi_rx_bit_strobe=1 in the same cycle as the data update.
  - Bit counter increments and wraps 7->0.
- Byte completion, when the received bit index is 7:
  - spi_rx_strobe=1 in the same cycle.
  - spi_rx_cmd=1 as well if first_byte is set; first_byte then clears.
  - Consequence: at the bit-6 strobe, spi_rx_data[6:0] holds the seven bits received so far.
- Transmit, shift register tx_sr, state bit tx_started, and a one-byte pending buffer:
  - spi_miso = tx_sr[7]. Each SCLK falling edge with /CS low does tx_sr <= {tx_sr[6:0],1}, except the falling edge after bit 7, which starts a new slot.
  - Slot start: load the pending byte if valid (pending then cleared). Otherwise load IDLE_TX and set tx_underrun, unless it is the first slot of the transaction, which sends IDLE_TX silently.
  - A slot is "open" from byte completion until the first falling edge of the next byte.
  - spi_tx_strobe while the slot is open and the first bit has not yet been shifted: tx_sr is loaded directly and MISO updates in the next clk. This is the immediate-update path.
  - spi_tx_strobe after the first bit of the slot has shifted: the byte goes to pending for the next slot and tx_late is set.
  - spi_tx_strobe while pending is already full: overwrite pending and set tx_late.
  - spi_tx_strobe in the same cycle as a slot-start edge: the strobe wins and its data is loaded into tx_sr.
- spi_miso_oe = spi_output_enable & ~spi_cs, registered with 1 clk latency.
- An SCLK edge coincident with /CS rising is discarded. A partial byte is dropped with no spi_rx_strobe.

Optional Feature:
- Macro: SPI_DEVICE_STATS_EN.
- When defined:
  - Adds output ports stat_bytes (32 bits), which counts spi_rx_strobe pulses, and stat_xfers (16 bits), which counts /CS falling edges.
  - Both reset to 0 and wrap on overflow.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- /CS low, mode-0 byte 0x03 at clk/8 -> bit strobes with spi_rx_bit 0..7; on the final cycle spi_rx_data=0x03 with spi_rx_strobe=1 and spi_rx_cmd=1. A second byte 0x12 gives spi_rx_strobe=1 and spi_rx_cmd=0.
- Send 0x9F, then the engine pulses spi_tx_strobe=0xC2 within 2 clk of the byte-0 spi_rx_strobe with spi_output_enable=1 -> MISO bits of byte 1 read 0xC2; tx_late=0; tx_underrun=0.
- Engine strobes 0xA5 after the 3rd falling edge of byte 1 -> byte 1 reads 0xFF, byte 2 reads 0xA5, tx_late=1.
- No tx strobe for byte 2 of a 3-byte transfer -> byte 2 reads 0xFF and tx_underrun=1.
- /CS deasserted after 5 bits -> no spi_rx_strobe; the next transaction's first byte asserts spi_rx_cmd; spi_miso_oe=0 within 1 clk of synchronized /CS high.
- reset pulled low mid-byte -> all outputs return to reset values immediately; after release, a full byte 0x5A is received correctly with spi_rx_cmd=1.

Source files
------------

// File: rtl/spi_device_if.sv
/*------------------------------------------------------------------------------
 * spi_device_if : engine-side bundle between spi_device and the command engine
 * Revision      : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

interface spi_device_if;
  logic       spi_output_enable;
  logic       spi_cs;
  logic [7:0] spi_rx_data;
  logic [2:0] spi_rx_bit;
  logic       spi_rx_bit_strobe;
  logic       spi_rx_strobe;
  logic       spi_rx_cmd;
  logic [7:0] spi_tx_data;
  logic       spi_tx_strobe;
  logic       tx_late;
  logic       tx_underrun;

  modport master (
    output spi_output_enable, spi_tx_data, spi_tx_strobe,
    input  spi_cs, spi_rx_data, spi_rx_bit, spi_rx_bit_strobe,
           spi_rx_strobe, spi_rx_cmd, tx_late, tx_underrun
  );

  modport slave (
    input  spi_output_enable, spi_tx_data, spi_tx_strobe,
    output spi_cs, spi_rx_data, spi_rx_bit, spi_rx_bit_strobe,
           spi_rx_strobe, spi_rx_cmd, tx_late, tx_underrun
  );
endinterface

`default_nettype wire

// File: rtl/spi_device.sv
/*------------------------------------------------------------------------------
 * spi_device : oversampled SPI mode-0 target front end (rx strobes, tx slots).
 *              Define SPI_DEVICE_STATS_EN to add byte/transfer counters.
 * Revision   : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module spi_device #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk_pin,
  input  logic        spi_cs_pin,
  input  logic        spi_mosi_pin,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  spi_device_if.slave eng
`ifdef SPI_DEVICE_STATS_EN
  ,
  output logic [31:0] stat_bytes,
  output logic [15:0] stat_xfers
`endif
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q, cs_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       rise, fall, slot_start, shift;

  logic [2:0] bit_cnt, rx_bit;
  logic [7:0] rx_data, tx_sr, pend;
  logic       first_byte, rx_bit_strobe, rx_strobe, rx_cmd;
  logic       tx_started, slot_loaded, idle_fill, pend_valid;
  logic       tx_late, tx_underrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_pin};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edges are only meaningful while the synchronized /CS is low.
  assign rise       = sclk_s & ~sclk_q & ~cs_s;
  assign fall       = ~sclk_s & sclk_q & ~cs_s;
  assign slot_start = fall & (bit_cnt == 3'd0);
  assign shift      = fall & (bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt       <= '0;
      first_byte    <= 1'b1;
      rx_data       <= '0;
      rx_bit        <= '0;
      rx_bit_strobe <= 1'b0;
      rx_strobe     <= 1'b0;
      rx_cmd        <= 1'b0;
      tx_sr         <= 8'hFF;
      tx_started    <= 1'b0;
      slot_loaded   <= 1'b1;
      idle_fill     <= 1'b0;
      pend          <= '0;
      pend_valid    <= 1'b0;
      tx_late       <= 1'b0;
      tx_underrun   <= 1'b0;
      spi_miso_oe   <= 1'b0;
    end else begin
      rx_bit_strobe <= 1'b0;
      rx_strobe     <= 1'b0;
      rx_cmd        <= 1'b0;
      spi_miso_oe   <= eng.spi_output_enable & ~cs_s;
      if (cs_s) begin
        bit_cnt     <= '0;
        first_byte  <= 1'b1;
        tx_sr       <= IDLE_TX;
        tx_started  <= 1'b0;
        slot_loaded <= 1'b1;
        idle_fill   <= 1'b0;
        pend_valid  <= 1'b0;
      end else begin
        if (rise) begin
          rx_data       <= {rx_data[6:0], mosi_s};
          rx_bit        <= bit_cnt;
          rx_bit_strobe <= 1'b1;
          bit_cnt       <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_strobe   <= 1'b1;
            rx_cmd      <= first_byte;
            first_byte  <= 1'b0;
            tx_started  <= 1'b0;
            slot_loaded <= 1'b0;
          end
        end
        // A strobe on the slot-start edge, or before the slot's first shift with
        // nothing queued, goes straight into the shifter.
        if (eng.spi_tx_strobe && (slot_start || (!tx_started && !shift && !pend_valid))) begin
          tx_sr       <= eng.spi_tx_data;
          slot_loaded <= 1'b1;
          idle_fill   <= 1'b0;
        end else begin
          if (slot_start) begin
            slot_loaded <= 1'b1;
            if (slot_loaded) begin
              idle_fill <= 1'b0;
            end else if (pend_valid) begin
              tx_sr      <= pend;
              pend_valid <= 1'b0;
              idle_fill  <= 1'b0;
            end else begin
              tx_sr     <= IDLE_TX;
              idle_fill <= 1'b1;
            end
          end else if (shift) begin
            tx_sr      <= {tx_sr[6:0], 1'b1};
            tx_started <= 1'b1;
            // Underrun is flagged once an unsupplied idle byte actually goes out.
            if (!tx_started && idle_fill) begin
              tx_underrun <= 1'b1;
              idle_fill   <= 1'b0;
            end
          end
          if (eng.spi_tx_strobe) begin
            pend       <= eng.spi_tx_data;
            pend_valid <= 1'b1;
            tx_late    <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_miso              = tx_sr[7];
  assign eng.spi_cs            = cs_s;
  assign eng.spi_rx_data       = rx_data;
  assign eng.spi_rx_bit        = rx_bit;
  assign eng.spi_rx_bit_strobe = rx_bit_strobe;
  assign eng.spi_rx_strobe     = rx_strobe;
  assign eng.spi_rx_cmd        = rx_cmd;
  assign eng.tx_late           = tx_late;
  assign eng.tx_underrun       = tx_underrun;

`ifdef SPI_DEVICE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_bytes <= '0;
      stat_xfers <= '0;
    end else begin
      if (rise && bit_cnt == 3'd7) stat_bytes <= stat_bytes + 32'd1;
      if (cs_q && !cs_s)           stat_xfers <= stat_xfers + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_device.sv
/*------------------------------------------------------------------------------
 * tb_spi_device : directed + randomized SPI mode-0 transactions against a
 *                 slot-level model of the rx stream and MISO byte sequence.
 * Revision      : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_spi_device;
  logic clk = 1'b0;
  logic reset;
  logic spi_clk_pin, spi_cs_pin, spi_mosi_pin;
  wire  spi_miso, spi_miso_oe;

  spi_device_if bus();

`ifdef SPI_DEVICE_STATS_EN
  wire [31:0] stat_bytes;
  wire [15:0] stat_xfers;
`endif

  spi_device dut (
    .clk          (clk),
    .reset        (reset),
    .spi_clk_pin  (spi_clk_pin),
    .spi_cs_pin   (spi_cs_pin),
    .spi_mosi_pin (spi_mosi_pin),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .eng          (bus)
`ifdef SPI_DEVICE_STATS_EN
    ,
    .stat_bytes   (stat_bytes),
    .stat_xfers   (stat_xfers)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction plan: per byte k, MOSI byte, early (in-slot) and late tx strobes.
  int         n;
  logic [7:0] mo [8];
  logic [7:0] ed [8];
  logic [7:0] ld [8];
  bit         early [8];
  bit         late [8];
  logic [7:0] got [8];
  logic [7:0] expm [8];
  bit         exp_late, exp_under;

  logic [8:0] byteq[$];
  int         bitq[$];

  always @(negedge clk) begin
    if (bus.spi_rx_bit_strobe) bitq.push_back(int'(bus.spi_rx_bit));
    if (bus.spi_rx_strobe || bus.spi_rx_cmd) byteq.push_back({bus.spi_rx_cmd, bus.spi_rx_data});
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 8; k++) begin
      mo[k] = 8'h00; ed[k] = 8'h00; ld[k] = 8'h00;
      early[k] = 1'b0; late[k] = 1'b0; got[k] = 8'h00;
    end
  endtask

  task automatic engine_tick(input int k, input int b, input int ph, input int c);
    bus.spi_tx_strobe = 1'b0;
    if (ph == 1 && b == 7 && c == 3 && k + 1 < n && early[k+1]) begin
      bus.spi_tx_strobe = 1'b1;
      bus.spi_tx_data   = ed[k+1];
    end
    if (ph == 0 && b == 5 && c == 1 && late[k]) begin
      bus.spi_tx_strobe = 1'b1;
      bus.spi_tx_data   = ld[k];
    end
  endtask

  task automatic send_bit(input int k, input int b);
    spi_mosi_pin = mo[k][7-b];
    for (int c = 0; c < 4; c++) begin engine_tick(k, b, 0, c); @(negedge clk); end
    spi_clk_pin = 1'b1;
    got[k][7-b] = spi_miso;
    for (int c = 0; c < 4; c++) begin engine_tick(k, b, 1, c); @(negedge clk); end
    spi_clk_pin = 1'b0;
  endtask

  task automatic xfer(input int nbits);
    int t;
    byteq.delete();
    bitq.delete();
    spi_cs_pin = 1'b0;
    repeat (4) @(negedge clk);
    chk("miso_oe_active", 0, spi_miso_oe, 1);
    for (int i = 0; i < nbits; i++) send_bit(i / 8, i % 8);
    bus.spi_tx_strobe = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs_pin = 1'b1;
    t = 0;
    while (bus.spi_cs !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("cs_sync_high", 0, bus.spi_cs, 1);
    @(negedge clk);
    chk("miso_oe_drop", 0, spi_miso_oe, 0);
    repeat (4) @(negedge clk);
  endtask

  // Slot-level view: byte 0 is idle; an in-slot strobe supplies its slot, a late
  // strobe is carried to the following slot; an unsupplied slot sends idle.
  task automatic model();
    bit         carry_v;
    logic [7:0] carry;
    carry_v = 1'b0;
    carry   = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (k == 0) expm[k] = 8'hFF;
      else if (early[k]) begin
        expm[k] = ed[k];
        if (carry_v) exp_late = 1'b1;
        carry_v = 1'b0;
      end else if (carry_v) begin
        expm[k] = carry;
        carry_v = 1'b0;
      end else begin
        expm[k]   = 8'hFF;
        exp_under = 1'b1;
      end
      if (late[k]) begin
        carry    = ld[k];
        carry_v  = 1'b1;
        exp_late = 1'b1;
      end
    end
  endtask

  task automatic check_xfer();
    model();
    chk("rx_byte_count", 0, byteq.size(), n);
    for (int k = 0; k < n && k < byteq.size(); k++) begin
      chk("rx_data", k, byteq[k][7:0], mo[k]);
      chk("rx_cmd", k, byteq[k][8], (k == 0) ? 1 : 0);
    end
    for (int k = 0; k < n; k++) chk("miso_byte", k, got[k], expm[k]);
    chk("tx_late", 0, bus.tx_late, exp_late);
    chk("tx_underrun", 0, bus.tx_underrun, exp_under);
  endtask

  task automatic run(input int nbytes);
    n = nbytes;
    xfer(n * 8);
    check_xfer();
  endtask

  task automatic check_reset_state();
    chk("rst_miso", 0, spi_miso, 1);
    chk("rst_miso_oe", 0, spi_miso_oe, 0);
    chk("rst_cs", 0, bus.spi_cs, 1);
    chk("rst_rx_data", 0, bus.spi_rx_data, 0);
    chk("rst_rx_bit", 0, bus.spi_rx_bit, 0);
    chk("rst_strobes", 0, {bus.spi_rx_bit_strobe, bus.spi_rx_strobe, bus.spi_rx_cmd}, 0);
    chk("rst_flags", 0, {bus.tx_late, bus.tx_underrun}, 0);
  endtask

  initial begin
    reset = 1'b0;
    spi_clk_pin = 1'b0; spi_cs_pin = 1'b1; spi_mosi_pin = 1'b0;
    bus.spi_output_enable = 1'b1;
    bus.spi_tx_data = 8'h00; bus.spi_tx_strobe = 1'b0;
    exp_late = 1'b0; exp_under = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 0x9F command; engine supplies 0xC2 right after the byte strobe.
    clear_plan();
    mo[0] = 8'h9F; mo[1] = 8'h00; early[1] = 1'b1; ed[1] = 8'hC2;
    run(2);

    // Three bytes, nothing supplied for byte 2.
    clear_plan();
    mo[0] = 8'h0B; mo[1] = 8'h44; mo[2] = 8'h81; early[1] = 1'b1; ed[1] = 8'h3C;
    run(3);

    // 0xA5 arrives mid byte 1: byte 1 idles, byte 2 carries it.
    clear_plan();
    mo[0] = 8'h05; mo[1] = 8'h6E; mo[2] = 8'hD1; late[1] = 1'b1; ld[1] = 8'hA5;
    run(3);

    // Plain receive of 0x03, 0x12 with bit index sequence.
    clear_plan();
    mo[0] = 8'h03; mo[1] = 8'h12;
    run(2);
    chk("bit_strobe_count", 0, bitq.size(), 16);
    for (int i = 0; i < 16 && i < bitq.size(); i++) chk("rx_bit_seq", i, bitq[i], i % 8);

    // Aborted byte after 5 bits, then a fresh command byte.
    clear_plan();
    n = 1; mo[0] = 8'hB6;
    xfer(5);
    chk("partial_no_byte", 0, byteq.size(), 0);
    chk("partial_bits", 0, bitq.size(), 5);
    clear_plan();
    mo[0] = 8'h77;
    run(1);

    // Randomized transactions.
    for (int r = 0; r < 6; r++) begin
      int nb;
      clear_plan();
      nb = $urandom_range(2, 5);
      for (int k = 0; k < nb; k++) begin
        mo[k] = 8'($urandom);
        ed[k] = 8'($urandom);
        ld[k] = 8'($urandom);
        early[k] = (k > 0) && ($urandom_range(0, 1) == 1);
        late[k]  = ($urandom_range(0, 3) == 0);
      end
      run(nb);
    end

    // Reset asserted mid-byte clears everything immediately.
    clear_plan();
    n = 1; mo[0] = 8'hE7;
    byteq.delete();
    spi_cs_pin = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < 3; b++) send_bit(0, b);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state();
    spi_cs_pin = 1'b1; spi_clk_pin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_late = 1'b0; exp_under = 1'b0;
    repeat (4) @(negedge clk);
    clear_plan();
    mo[0] = 8'h5A;
    run(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
